// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo_if
// Description : Bundle of the receive-FIFO signals. The receiver-side push
//               strobes, the pop request and the status clear travel toward
//               the FIFO. The head word, level flags and status counters
//               travel back out.
//               master : drives rx_data/rx_done/rx_error/rd_en/stat_clr
//               slave  : the FIFO; drives rd_data/rd_err/flags/count/status
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
);
    logic [DATA_WIDTH-1:0]      rx_data;
    logic                       rx_done;
    logic                       rx_error;
    logic                       rd_en;
    logic                       stat_clr;
    logic [DATA_WIDTH-1:0]      rd_data;
    logic                       rd_err;
    logic                       empty;
    logic                       full;
    logic                       almost_full;
    logic [$clog2(DEPTH):0]     count;
    logic                       overrun;
    logic [7:0]                 err_cnt;

    modport master (
        output rx_data, rx_done, rx_error, rd_en, stat_clr,
        input  rd_data, rd_err, empty, full, almost_full, count, overrun, err_cnt
    );

    modport slave (
        input  rx_data, rx_done, rx_error, rd_en, stat_clr,
        output rd_data, rd_err, empty, full, almost_full, count, overrun, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : First-word-fall-through receive buffer behind the UART
//               receiver. Each completed frame is stored together with an
//               error tag. A sticky overrun flag records dropped words, and a
//               saturating counter records receiver error pulses.
// Ports       : clk   - block clock
//               rst_n - asynchronous active-low reset
//               bus   - uart_rx_fifo_if.slave (push, pop, flags, status)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 2
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_rx_fifo_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_DEPTH    = CW'(DEPTH);
    localparam logic [CW-1:0] C_AF_LEVEL = CW'(AF_LEVEL);
    localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] C_PTR_ONE  = AW'(1);

    // Each entry holds the error tag in the MSB above the payload.
    typedef logic [DATA_WIDTH:0] entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               err_pend_q, err_pend_d;
    logic               overrun_q, overrun_d;
    logic [7:0]         err_cnt_q, err_cnt_d;

    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic               w_tag;

    assign w_empty = (count_q == '0);
    assign w_full  = (count_q == C_DEPTH);
    assign w_pop   = bus.rd_en & ~w_empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_push  = bus.rx_done & (~w_full | w_pop);
    assign w_drop  = bus.rx_done & w_full & ~w_pop;
    // An error seen in the same cycle as rx_done belongs to this word too.
    assign w_tag   = err_pend_q | bus.rx_error;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        err_pend_d = err_pend_q;
        overrun_d  = overrun_q;
        err_cnt_d  = err_cnt_q;

        if (w_push) begin
            mem_d[wr_ptr_q] = {w_tag, bus.rx_data};
            wr_ptr_d        = wr_ptr_q + C_PTR_ONE;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + C_PTR_ONE;
        end
        if (w_push && !w_pop) begin
            count_d = count_q + C_CNT_ONE;
        end else if (w_pop && !w_push) begin
            count_d = count_q - C_CNT_ONE;
        end

        // The pending tag is consumed by every completed frame. This includes
        // a dropped frame, so its tag is discarded along with the word.
        if (bus.rx_done) begin
            err_pend_d = 1'b0;
        end else if (bus.rx_error) begin
            err_pend_d = 1'b1;
        end

        // Set and increment events take priority over the software clear.
        if (w_drop) begin
            overrun_d = 1'b1;
        end else if (bus.stat_clr) begin
            overrun_d = 1'b0;
        end

        if (bus.rx_error) begin
            if (bus.stat_clr) begin
                err_cnt_d = 8'd1;
            end else if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end else if (bus.stat_clr) begin
            err_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_pend_q <= 1'b0;
            overrun_q  <= 1'b0;
            err_cnt_q  <= 8'd0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            err_pend_q <= err_pend_d;
            overrun_q  <= overrun_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // The head word falls through combinationally from the read pointer.
    assign bus.rd_data     = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
    assign bus.rd_err      = mem_q[rd_ptr_q][DATA_WIDTH];
    assign bus.empty       = w_empty;
    assign bus.full        = w_full;
    assign bus.almost_full = (count_q >= C_AF_LEVEL);
    assign bus.count       = count_q;
    assign bus.overrun     = overrun_q;
    assign bus.err_cnt     = err_cnt_q;
endmodule
`default_nettype wire
